pulse_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource among N requesters. Example resource: a display/counter update unit.
- Each requester delivers single-cycle request pulses, typically the outputs of per-button rising-edge detectors.
- Pulses are latched as pending requests, granted one at a time, and held until the resource signals done or a timeout expires.
- Sits between the edge-detect front end and the shared datapath.

---
 rtl/pulse_arbiter.sv | 135 +++++++++++++
 tb/tb_pulse_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter: latches single-cycle request pulses and grants one
// requester at a time, holding the grant until done or a wait timeout.
module pulse_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N-1:0]           req_pulse,
    input  logic                   done,
    output logic [N-1:0]           grant,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy,
    output logic [N-1:0]           pending,
    output logic [N-1:0]           overflow,
    output logic                   timeout_err
);

    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned CW  = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     overflow_q, overflow_d;
    logic             timeout_err_q, timeout_err_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sel_valid;
    logic [IDW-1:0]   sel_idx;
    logic [N-1:0]     sel_hit;

    // Rotating search: first pending bit at or after last_grant+1, wrapping.
    always_comb begin
        int unsigned    pos;
        logic [IDW-1:0] pos_idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        pos       = 0;
        pos_idx   = '0;
        if (state_q == IDLE) begin
            for (int unsigned k = 1; k <= N; k++) begin
                pos     = (32'(last_q) + k) % N;
                pos_idx = IDW'(pos);
                if (!sel_valid && pending_q[pos_idx]) begin
                    sel_valid = 1'b1;
                    sel_idx   = pos_idx;
                end
            end
        end
    end

    // A pulse on the selection edge re-queues; otherwise a repeat pulse is dropped and flagged.
    always_comb begin
        sel_hit    = sel_valid ? (N'(1) << sel_idx) : '0;
        pending_d  = req_pulse | (pending_q & ~sel_hit);
        overflow_d = overflow_q | (req_pulse & pending_q & ~sel_hit);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d    = BUSY;
                    grant_d    = N'(1) << sel_idx;
                    grant_id_d = sel_idx;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // done takes precedence over a coincident timeout
                if (done || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    busy_d        = 1'b0;
                    last_d        = grant_id_q;
                    cnt_d         = '0;
                    timeout_err_d = !done;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            pending_q     <= '0;
            overflow_q    <= '0;
            timeout_err_q <= 1'b0;
            last_q        <= IDW'(N - 1);
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter (N=4, TIMEOUT=16) with hand-computed expectations.
module tb_pulse_arbiter;

    localparam int unsigned N       = 4;
    localparam int unsigned TIMEOUT = 16;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_pulse;
    logic         done;
    logic [3:0]   grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic [3:0]   pending;
    logic [3:0]   overflow;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;

    pulse_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_pulse   (req_pulse),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        req_pulse = v;
        cyc();
        req_pulse = 4'b0000;
    endtask

    task automatic finish_grant();
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_pulse = 4'b0001;
        done      = 1'b0;
        repeat (3) cyc();
        chk("rst_grant",    32'(grant), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy",     32'(busy), 32'h0);
        chk("rst_pending",  32'(pending), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_tmo",      32'(timeout_err), 32'h0);
        req_pulse = 4'b0000;
        reset_n   = 1'b1;
        cyc();
        cyc();
        chk("post_rst_pending", 32'(pending), 32'h0);
        chk("post_rst_grant",   32'(grant), 32'h0);

        // Single pulse on requester 2
        pulse(4'b0100);
        chk("single_pending", 32'(pending), 32'h4);
        chk("single_nogrant", 32'(grant), 32'h0);
        cyc();
        chk("single_grant",    32'(grant), 32'h4);
        chk("single_grant_id", 32'(grant_id), 32'h2);
        chk("single_busy",     32'(busy), 32'h1);
        chk("single_pend_clr", 32'(pending), 32'h0);
        cyc();
        cyc();
        chk("single_held", 32'(grant), 32'h4);
        finish_grant();
        chk("single_release", 32'(grant), 32'h0);
        chk("single_idle",    32'(busy), 32'h0);
        chk("single_id_hold", 32'(grant_id), 32'h2);

        // All four at once from a fresh reset: order 0,1,2,3
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        pulse(4'b1111);
        chk("all_pending", 32'(pending), 32'hF);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("all_grant",    32'(grant), 32'(1 << i));
            chk("all_grant_id", 32'(grant_id), 32'(i));
            chk("all_pending_after", 32'(pending), 32'(4'hF & ~((2 << i) - 1)));
            finish_grant();
            chk("all_idle_gap", 32'(busy), 32'h0);
        end
        chk("all_pending_end", 32'(pending), 32'h0);
        chk("all_overflow",    32'(overflow), 32'h0);

        // Overflow on requester 1 while requester 0 holds the grant
        pulse(4'b0001);
        cyc();
        chk("ovf_grant0", 32'(grant), 32'h1);
        pulse(4'b0010);
        chk("ovf_first_pend", 32'(overflow), 32'h0);
        pulse(4'b0010);
        chk("ovf_set",     32'(overflow), 32'h2);
        chk("ovf_pending", 32'(pending), 32'h2);
        finish_grant();
        chk("ovf_rel0", 32'(grant), 32'h0);
        pulse(4'b0010);
        chk("requeue_grant",    32'(grant), 32'h2);
        chk("requeue_grant_id", 32'(grant_id), 32'h1);
        chk("requeue_pending",  32'(pending), 32'h2);
        chk("requeue_no_ovf",   32'(overflow), 32'h2);
        finish_grant();
        chk("requeue_rel", 32'(grant), 32'h0);
        cyc();
        chk("requeue_second", 32'(grant), 32'h2);
        chk("requeue_pclr",   32'(pending), 32'h0);
        finish_grant();

        // Timeout with done held low
        pulse(4'b1000);
        cyc();
        chk("tmo_grant", 32'(grant), 32'h8);
        for (int j = 0; j < 15; j++) begin
            cyc();
            chk("tmo_held", 32'({busy, timeout_err}), 32'h2);
        end
        cyc();
        chk("tmo_release", 32'(grant), 32'h0);
        chk("tmo_err",     32'(timeout_err), 32'h1);
        cyc();
        chk("tmo_err_pulse", 32'(timeout_err), 32'h0);

        // done coinciding with the timeout cycle wins
        pulse(4'b0100);
        cyc();
        chk("tmo2_grant", 32'(grant), 32'h4);
        repeat (15) cyc();
        chk("tmo2_held", 32'(grant), 32'h4);
        finish_grant();
        chk("tmo2_release", 32'(grant), 32'h0);
        chk("tmo2_no_err",  32'(timeout_err), 32'h0);
        cyc();
        chk("tmo2_no_err2", 32'(timeout_err), 32'h0);

        // Asynchronous reset in the middle of a grant
        pulse(4'b0001);
        cyc();
        pulse(4'b1010);
        chk("mid_pending", 32'(pending), 32'hA);
        chk("mid_busy",    32'(busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_grant",    32'(grant), 32'h0);
        chk("async_pending",  32'(pending), 32'h0);
        chk("async_busy",     32'(busy), 32'h0);
        chk("async_overflow", 32'(overflow), 32'h0);
        chk("async_grant_id", 32'(grant_id), 32'h0);
        #1;
        reset_n = 1'b1;
        cyc();
        pulse(4'b1001);
        cyc();
        chk("ptr_first",    32'(grant), 32'h1);
        chk("ptr_first_id", 32'(grant_id), 32'h0);
        finish_grant();
        cyc();
        chk("ptr_second",    32'(grant), 32'h8);
        chk("ptr_second_id", 32'(grant_id), 32'h3);
        finish_grant();
        chk("ptr_end_pending", 32'(pending), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
